// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared widths, register count and state type for the write arbiter
package reg_file_pkg;

  localparam int DW       = 16;
  localparam int AW       = 4;
  localparam int NUM_REGS = 14;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Widened by one bit so the compare stays exact even if NUM_REGS == 2**AW.
  function automatic logic addr_legal(input logic [AW-1:0] addr);
    return {1'b0, addr} < (AW+1)'(NUM_REGS);
  endfunction

endpackage

// File: rtl/reg_file_wr_arbiter_if.sv
// rtl/reg_file_wr_arbiter_if.sv - requester, clear-control and register-bank write signals
interface reg_file_wr_arbiter_if #(
  parameter int NREQ = 4
);
  import reg_file_pkg::*;

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               clr_start;
  logic               busy;
  logic               clr_done;
  logic               err;
  logic [IDW-1:0]     err_id;
  logic               rf_we;
  logic [AW-1:0]      rf_addr;
  logic [DW-1:0]      rf_data;

  modport master (
    output req_valid, req_addr, req_data, clr_start,
    input  req_ready, busy, clr_done, err, err_id, rf_we, rf_addr, rf_data
  );

  modport slave (
    input  req_valid, req_addr, req_data, clr_start,
    output req_ready, busy, clr_done, err, err_id, rf_we, rf_addr, rf_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  winner,
  output logic            any_grant
);

  int idx;

  // Scan from farthest to nearest so the request closest to ptr is the last write.
  always_comb begin
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        winner     = IDW'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// rtl/reg_file_wr_arbiter.sv - round-robin write-port sharing with a bulk-clear sequencer
module reg_file_wr_arbiter
  import reg_file_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_file_wr_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [AW-1:0] LAST_REG = AW'(NUM_REGS - 1);

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  winner;
  logic [NREQ-1:0] grant;
  logic            any_grant;
  logic            take;
  logic [AW-1:0]   clr_cnt;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  assign win_addr = bus.req_addr[int'(winner) * AW +: AW];
  assign win_data = bus.req_data[int'(winner) * DW +: DW];

  // A clear request outranks every requester in the cycle it is seen.
  always_comb begin
    state_nxt     = state;
    take          = 1'b0;
    bus.req_ready = '0;
    case (state)
      ARB: begin
        if (bus.clr_start) begin
          state_nxt = CLEAR;
        end else if (rst_n) begin
          bus.req_ready = grant;
          take          = any_grant;
        end
      end
      CLEAR: begin
        if (clr_cnt == LAST_REG) begin
          state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB;
      rr_ptr       <= '0;
      clr_cnt      <= '0;
      bus.rf_we    <= 1'b0;
      bus.rf_addr  <= '0;
      bus.rf_data  <= '0;
      bus.busy     <= 1'b0;
      bus.clr_done <= 1'b0;
      bus.err      <= 1'b0;
      bus.err_id   <= '0;
    end else begin
      state        <= state_nxt;
      bus.rf_we    <= 1'b0;
      bus.err      <= 1'b0;
      bus.clr_done <= 1'b0;
      case (state)
        ARB: begin
          if (bus.clr_start) begin
            clr_cnt      <= '0;
            bus.busy     <= 1'b1;
            bus.rf_we    <= 1'b1;
            bus.rf_addr  <= '0;
            bus.rf_data  <= '0;
            bus.clr_done <= (NUM_REGS == 1);
          end else if (take) begin
            rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
            if (addr_legal(win_addr)) begin
              bus.rf_we   <= 1'b1;
              bus.rf_addr <= win_addr;
              bus.rf_data <= win_data;
            end else begin
              bus.err    <= 1'b1;
              bus.err_id <= winner;
            end
          end
        end
        CLEAR: begin
          // clr_cnt is the address already on rf_addr; the last one ends the sequence.
          if (clr_cnt == LAST_REG) begin
            bus.busy <= 1'b0;
          end else begin
            clr_cnt      <= clr_cnt + 1'b1;
            bus.rf_we    <= 1'b1;
            bus.rf_addr  <= clr_cnt + 1'b1;
            bus.rf_data  <= '0;
            bus.clr_done <= (clr_cnt + 1'b1 == LAST_REG);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// tb/tb_reg_file_wr_arbiter.sv - randomized self-checking bench against a behavioural arbiter model
module tb_reg_file_wr_arbiter;
  import reg_file_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_wr_arbiter_if #(.NREQ(NREQ)) bus ();

  reg_file_wr_arbiter #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state: pointer, clear start edge, and what the bank port should show.
  int             m_ptr;
  bit             m_clearing;
  int             m_clr_e0;
  int             edge_no;
  logic           m_we, m_busy, m_done, m_err;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_data;
  logic [IDW-1:0] m_err_id;
  int             last_grant;

  function automatic int model_winner(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_clearing = 0; m_clr_e0 = 0; edge_no = 0;
    m_we = 0; m_busy = 0; m_done = 0; m_err = 0;
    m_addr = '0; m_data = '0; m_err_id = '0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]          = 1'b1;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_data[i*DW +: DW]  = d;
  endtask

  // Entered just after a falling edge with inputs driven; leaves at the next falling edge.
  task automatic step(input bit refill);
    int             w;
    int             k;
    bit             in_clear;
    bit             start;
    logic [NREQ-1:0] exp_ready;
    logic [AW-1:0]  a;
    logic [DW-1:0]  d;
    in_clear  = m_clearing && (edge_no - m_clr_e0 >= 1);
    start     = !in_clear && bus.clr_start;
    w         = -1;
    exp_ready = '0;
    if (!in_clear && !bus.clr_start) begin
      w = model_winner(bus.req_valid, m_ptr);
      if (w >= 0) exp_ready[w] = 1'b1;
    end
    a = '0; d = '0;
    if (w >= 0) begin
      a = bus.req_addr[w*AW +: AW];
      d = bus.req_data[w*DW +: DW];
    end
    #1;
    check("req_ready", bus.req_ready, exp_ready);
    last_grant = -1;
    for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) last_grant = i;
    @(posedge clk);
    m_we = 0; m_done = 0; m_err = 0;
    if (in_clear) begin
      k = edge_no - m_clr_e0;
      if (k < NUM_REGS) begin
        m_we = 1; m_addr = AW'(k); m_data = '0; m_busy = 1; m_done = (k == NUM_REGS - 1);
      end else begin
        m_busy = 0; m_clearing = 0;
      end
    end else if (start) begin
      m_clearing = 1; m_clr_e0 = edge_no;
      m_we = 1; m_addr = '0; m_data = '0; m_busy = 1; m_done = (NUM_REGS == 1);
    end else if (w >= 0) begin
      m_ptr = (w + 1) % NREQ;
      if (a < NUM_REGS) begin
        m_we = 1; m_addr = a; m_data = d;
      end else begin
        m_err = 1; m_err_id = IDW'(w);
      end
    end
    edge_no++;
    #1;
    check("rf_we", bus.rf_we, m_we);
    check("rf_addr", bus.rf_addr, m_addr);
    check("rf_data", bus.rf_data, m_data);
    check("busy", bus.busy, m_busy);
    check("clr_done", bus.clr_done, m_done);
    check("err", bus.err, m_err);
    if (m_err) check("err_id", bus.err_id, m_err_id);
    bus.clr_start = 1'b0;
    if (w >= 0) begin
      if (refill) set_req(w, AW'($urandom_range(0, 15)), DW'($urandom));
      else bus.req_valid[w] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '1;
    bus.clr_start = 1'b0;
    #1;
    check("rst_ready", bus.req_ready, '0);
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_rf_addr", bus.rf_addr, 0);
    check("rst_rf_data", bus.rf_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_clr_done", bus.clr_done, 0);
    check("rst_err", bus.err, 0);
    check("rst_err_id", bus.err_id, 0);
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.clr_start = 1'b0;
    model_reset();
    do_reset();

    // single legal write
    set_req(0, 4'd3, 16'hA5A5);
    step(0);
    check("tp1_grant", last_grant, 0);
    check("tp1_rf_addr", bus.rf_addr, 3);
    check("tp1_rf_data", bus.rf_data, 16'hA5A5);

    // all requesters held: strict rotation, back-to-back writes
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 4), DW'(16'h1000 + i));
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("tp2_grant", last_grant, i % NREQ);
      check("tp2_we", bus.rf_we, 1);
    end
    bus.req_valid = '0;

    // pointer skips past the last winner
    do_reset();
    set_req(1, 4'd9, 16'h1111);
    step(0);
    check("tp3_first", last_grant, 1);
    set_req(0, 4'd2, 16'h2222);
    set_req(3, 4'd5, 16'h3333);
    step(0);
    check("tp3_rr_wins3", last_grant, 3);
    step(0);
    check("tp3_then0", last_grant, 0);

    // illegal address consumed, reported, bank port untouched
    set_req(2, 4'd14, 16'hDEAD);
    step(0);
    check("tp4_grant", last_grant, 2);
    check("tp4_err", bus.err, 1);
    check("tp4_err_id", bus.err_id, 2);
    check("tp4_addr_hold", bus.rf_addr, 2);

    // clear beats a same-cycle request, which then waits it out
    set_req(1, 4'd6, 16'h6666);
    bus.clr_start = 1'b1;
    step(0);
    check("tp5_no_grant", last_grant, -1);
    for (int i = 1; i <= NUM_REGS; i++) begin
      if (i == 3) bus.clr_start = 1'b1;
      step(0);
    end
    step(0);
    check("tp5_req1_after", last_grant, 1);

    // reset partway through a clear
    do_reset();
    bus.clr_start = 1'b1;
    step(0);
    for (int i = 0; i < 4; i++) step(0);
    check("tp6_mid_clear", bus.rf_addr, 4);
    #2;
    do_reset();
    for (int i = 0; i < NUM_REGS + 2; i++) step(0);
    set_req(0, 4'd7, 16'hBEEF);
    step(0);
    check("tp6_post_we", bus.rf_we, 1);
    check("tp6_post_data", bus.rf_data, 16'hBEEF);

    // random traffic with occasional clears, including ones issued mid-clear
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!bus.req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, AW'($urandom_range(0, 15)), DW'($urandom));
      bus.clr_start = ($urandom_range(0, 29) == 0);
      step(bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
